// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write/read-side schedulers
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int MAX_NREQ = 8;
    localparam int STAT_W   = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-port signals of the write arbiter
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 18
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic [DSIZE-1:0]      fifo_wdata;
    logic                  fifo_winc;
    logic                  fifo_wfull;
    logic                  fifo_w_almost_full;

    // slave: the arbiter itself; master: requesters plus FIFO flag source
    modport slave (
        input  req_valid, req_data, req_last, fifo_wfull, fifo_w_almost_full,
        output req_ready, fifo_wdata, fifo_winc
    );
    modport master (
        output req_valid, req_data, req_last, fifo_wfull, fifo_w_almost_full,
        input  req_ready, fifo_wdata, fifo_winc
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin priority picker (rr_pick)
module rr_pick #(
    parameter int N  = 4,
    parameter int GW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [GW-1:0] idx,
    output logic          found
);

    // Walk from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                found = 1'b1;
                idx   = GW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-granular round-robin arbiter for the async FIFO write port
// Optional per-requester beat / stall counters under FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NREQ      = 4,
    parameter int  DSIZE     = 18,
    parameter int  MAX_BURST = 16,
    localparam int GW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   wclk,
    input  logic                   wrst_n,
    fifo_wr_arbiter_if.slave       bus,
    output logic [GW-1:0]          grant_id,
    output logic                   busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] stat_beats,
    output logic [STAT_W-1:0]      stat_stall
`endif
);

    arb_state_t    state;
    logic [GW-1:0] rr_ptr;
    logic [7:0]    beat_cnt;
    logic [GW-1:0] pick_idx;
    logic          pick_found;
    logic          ready_int;
    logic          accept;
    logic          end_beat;

    rr_pick #(.N(NREQ), .GW(GW)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // almost_full leaves two slots of slack for the registered flag; wfull is the backstop
    always_comb begin
        ready_int = ~bus.fifo_w_almost_full & ~bus.fifo_wfull;
        accept    = (state == XFER) & bus.req_valid[grant_id] & ready_int;
        end_beat  = accept & (bus.req_last[grant_id] | (beat_cnt == 8'(MAX_BURST - 1)));
        bus.fifo_winc  = accept;
        bus.fifo_wdata = bus.req_data[int'(grant_id)*DSIZE +: DSIZE];
        bus.req_ready  = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = (state == XFER) & ready_int & (grant_id == GW'(i));
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        state    <= XFER;
                        busy     <= 1'b1;
                    end
                end
                XFER: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                    if (end_beat) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_W-1:0] beats_q [NREQ];
    logic [STAT_W-1:0] stall_q;
    logic              stall_now;

    assign stall_now = (state == XFER) & bus.req_valid[grant_id] & ~ready_int;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                beats_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            if (accept && (beats_q[grant_id] != '1)) begin
                beats_q[grant_id] <= beats_q[grant_id] + 1'b1;
            end
            if (stall_now && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    always_comb begin
        stat_beats = '0;
        for (int i = 0; i < NREQ; i++) begin
            stat_beats[i*STAT_W +: STAT_W] = beats_q[i];
        end
    end

    assign stat_stall = stall_q;
`endif

endmodule
